bus_trace_card: RTL and testbench
=================================

# bus_trace_card

Parametrised bus-trace card for the SUBLEQ backplane. It sits on the shared data/addr/ctrl bus beside the control, clock, register, ALU and RAM cards and records bus state into a circular buffer. Capture is pre/post-trigger around a masked address match, and the buffer is read back oldest-first through a one-cycle request/valid port. It takes over from cycle-by-cycle printing of bus state and allows self-checking benches and on-target debug.

## Interface
- DATAWIDTH, 16: width of `data` and `addr`.
- CTRLWIDTH, 14: width of `ctrl`.
- DEPTH, 64: buffer entries. Power of two, ≥4.
- POST_TRIGGER, 16: samples stored after the trigger sample. Must be < DEPTH.

- clk  in  1  bus clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  DATAWIDTH  bus data, observed only.
- addr  in  DATAWIDTH  bus address, observed only.
- ctrl  in  CTRLWIDTH  bus control lines, observed only.
- arm  in  1  single-cycle pulse: clear buffer, enter ARMED.
- trig_addr  in  DATAWIDTH  trigger address.
- trig_mask  in  DATAWIDTH  bits that take part in the compare (1 = compared).
- rd_req  in  1  pop one entry. Honoured only in DONE.
- rd_valid  out  1  rd_data valid. High for one cycle.
- rd_data  out  2*DATAWIDTH+CTRLWIDTH  entry {addr, data, ctrl}.
- count  out  clog2(DEPTH)+1  entries held, or entries still to read in DONE.
- armed  out  1  state == ARMED.
- triggered  out  1  state == POST or DONE.
- done  out  1  state == DONE.

## Operation
- States: IDLE → ARMED → POST → DONE.
  - IDLE: nothing captured.
  - ARMED: pre-trigger capture. Ring write wraps and overwrites the oldest entry. count saturates at DEPTH.
  - ARMED → POST on match: (addr & trig_mask) == (trig_addr & trig_mask). The match cycle is always written as the trigger sample.
  - POST: writes POST_TRIGGER more qualifying samples, then → DONE. With POST_TRIGGER = 0, goes straight to DONE after the trigger sample.
  - DONE: capture stops. The read pointer starts at the oldest surviving entry, which is wr_ptr − count mod DEPTH.
- Sample qualification: see Configuration. The trigger sample always qualifies.
- arm in any state, including mid-readout:
  - wr_ptr = 0, count = 0, state = ARMED.
  - The bus sample in the arm cycle is not stored.
  - The trigger compare is inactive in the arm cycle.
- Reads:
  - rd_req in DONE with count > 0 pops the oldest entry and decrements count.
  - rd_req with count = 0, or outside DONE, is ignored: no rd_valid, no state change.
- After the last read the card stays in DONE with count = 0 until arm.
- rd_req and arm in the same cycle: arm wins, no rd_valid.
- Pointer arithmetic is modulo DEPTH. count never exceeds DEPTH.

## Timing
- Reset values (asynchronous on rst_n low): state IDLE, wr_ptr 0, rd_ptr 0, count 0, rd_valid 0, rd_data 0, armed/triggered/done 0.
- Bus inputs are sampled on the rising clk edge. The write lands in the same edge.
- Status outputs are registered and reflect the new state one cycle after the causing edge.
- Read latency: rd_req high at edge N gives rd_valid and rd_data at edge N+1. One pop per cycle is allowed back-to-back.
- rd_data holds its last value while rd_valid is low.
- Asserting rst_n low mid-capture or mid-readout discards all contents immediately.

## Configuration
- TRACE_CHANGE_ONLY_EN:
  - Defined: a sample qualifies only if {addr, data, ctrl} differs from the last written entry. The first sample after arm always qualifies. Idle bus cycles are compressed out, and POST_TRIGGER counts distinct samples.
  - Undefined: every clk cycle in ARMED/POST qualifies. The buffer is a plain cycle-by-cycle window.

## Test plan
- Reset: rst_n low mid-POST → all outputs 0 and state IDLE within the same cycle. rd_req afterwards gives no rd_valid.
- Basic window, DEPTH=8, POST_TRIGGER=2, every cycle, addr counting 0x0000..:
  - arm, then trig_addr=0x000A, mask=0xFFFF → done after the sample at addr 0x000C.
  - 8 reads give addr 0x0005..0x000C in order, then count=0.
- Masked trigger: trig_mask=0xFF00, trig_addr=0x1200 → triggers on the first addr in 0x1200..0x12FF, e.g. 0x1234.
- Short pre-trigger: trigger on the 2nd cycle after arm with POST_TRIGGER=2 → count=4 in DONE. Reads return exactly those 4 entries, then rd_req is ignored.
- Change-only (macro defined): bus held at {0x0003,0x00FF,0x0001} for 5 cycles, then changed → one entry for the held value.
- arm and rd_req in the same DONE cycle → no rd_valid, count=0, armed=1 next cycle.

Source files
------------

// File: rtl/bus_trace_card_if.sv
// rtl/bus_trace_card_if.sv - observed backplane bus plus trace readout port
interface bus_trace_card_if #(
  parameter int DATAWIDTH = 16,
  parameter int CTRLWIDTH = 14
);
  logic [DATAWIDTH-1:0]             data;
  logic [DATAWIDTH-1:0]             addr;
  logic [CTRLWIDTH-1:0]             ctrl;
  logic                             rd_req;
  logic                             rd_valid;
  logic [2*DATAWIDTH+CTRLWIDTH-1:0] rd_data;

  modport master (
    output data, addr, ctrl, rd_req,
    input  rd_valid, rd_data
  );

  modport slave (
    input  data, addr, ctrl, rd_req,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/bus_trace_card.sv
// rtl/bus_trace_card.sv - pre/post-trigger circular bus trace buffer
// Optional macro TRACE_CHANGE_ONLY_EN: store only samples that differ from the last stored entry.
module bus_trace_card #(
  parameter int DATAWIDTH    = 16,
  parameter int CTRLWIDTH    = 14,
  parameter int DEPTH        = 64,
  parameter int POST_TRIGGER = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bus_trace_card_if.slave          bus,
  input  logic                     arm,
  input  logic [DATAWIDTH-1:0]     trig_addr,
  input  logic [DATAWIDTH-1:0]     trig_mask,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     armed,
  output logic                     triggered,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2*DATAWIDTH + CTRLWIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] POST_LAST = AW'((POST_TRIGGER == 0) ? 0 : POST_TRIGGER - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] post_cnt;
  logic [EW-1:0] mem [DEPTH];

  logic [EW-1:0] sample;
  logic          match;
  logic          capturing;
  logic          qualify;
  logic          wr_en;
  logic          enter_done;
  logic [CW-1:0] count_inc;

  assign sample    = {bus.addr, bus.data, bus.ctrl};
  assign match     = ((bus.addr ^ trig_addr) & trig_mask) == '0;
  assign capturing = (state == S_ARMED) || (state == S_POST);

`ifdef TRACE_CHANGE_ONLY_EN
  logic [EW-1:0] last_entry;
  logic          first_sample;

  // The trigger sample is stored even if it repeats the previous entry.
  assign qualify = capturing &&
                   (first_sample || (sample != last_entry) || ((state == S_ARMED) && match));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_entry   <= '0;
      first_sample <= 1'b1;
    end else if (arm) begin
      first_sample <= 1'b1;
    end else if (wr_en) begin
      last_entry   <= sample;
      first_sample <= 1'b0;
    end
  end
`else
  assign qualify = capturing;
`endif

  // The arm cycle neither stores nor compares.
  assign wr_en     = qualify && !arm;
  assign count_inc = (count == COUNT_MAX) ? count : count + CW'(1);

  assign enter_done = wr_en &&
                      (((state == S_ARMED) && match && (POST_TRIGGER == 0)) ||
                       ((state == S_POST) && (post_cnt == POST_LAST)));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      post_cnt    <= '0;
      count       <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else if (arm) begin
      state        <= S_ARMED;
      wr_ptr       <= '0;
      post_cnt     <= '0;
      count        <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      if (wr_en) begin
        wr_ptr   <= wr_ptr + AW'(1);
        count    <= count_inc;
        post_cnt <= (state == S_POST) ? post_cnt + AW'(1) : '0;
      end
      if (enter_done) begin
        state  <= S_DONE;
        // Oldest survivor; a full buffer truncates count to 0 so rd_ptr lands on wr_ptr.
        rd_ptr <= wr_ptr + AW'(1) - count_inc[AW-1:0];
      end else if (wr_en && (state == S_ARMED) && match) begin
        state <= S_POST;
      end
      if ((state == S_DONE) && bus.rd_req && (count != '0)) begin
        bus.rd_data  <= mem[rd_ptr];
        bus.rd_valid <= 1'b1;
        rd_ptr       <= rd_ptr + AW'(1);
        count        <= count - CW'(1);
      end
    end
  end

  assign armed     = (state == S_ARMED);
  assign triggered = (state == S_POST) || (state == S_DONE);
  assign done      = (state == S_DONE);
endmodule

// File: tb/tb_bus_trace_card.sv
// tb/tb_bus_trace_card.sv - directed self-checking bench for bus_trace_card
module tb_bus_trace_card;
  localparam int DW = 16;
  localparam int CWD = 14;
  localparam int DEPTH = 8;
  localparam int POST = 2;
  localparam int EW = 2*DW + CWD;
  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0;
  logic [DW-1:0] trig_addr = '0;
  logic [DW-1:0] trig_mask = '0;
  logic [$clog2(DEPTH):0] count;
  logic armed, triggered, done;

  bus_trace_card_if #(.DATAWIDTH(DW), .CTRLWIDTH(CWD)) bif ();

  bus_trace_card #(.DATAWIDTH(DW), .CTRLWIDTH(CWD), .DEPTH(DEPTH), .POST_TRIGGER(POST)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave), .arm(arm),
    .trig_addr(trig_addr), .trig_mask(trig_mask), .count(count),
    .armed(armed), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: trace is a queue of stored entries, oldest first.
  ent_t q[$];
  int   m_state;
  int   post_left;
  logic m_valid;
  ent_t m_data;
  ent_t m_last;
  bit   m_first;
  ent_t s;
  bit   hit, qual;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_state = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_first = 1'b1;
    end else begin
      m_valid = 1'b0;
      s = {bif.addr, bif.data, bif.ctrl};
      if (arm) begin
        q.delete();
        m_state = 1;
        m_first = 1'b1;
      end else if (m_state == 1 || m_state == 2) begin
        hit  = (m_state == 1) && ((bif.addr & trig_mask) == (trig_addr & trig_mask));
        qual = 1'b1;
`ifdef TRACE_CHANGE_ONLY_EN
        qual = m_first || (s != m_last) || hit;
`endif
        if (qual) begin
          q.push_back(s);
          if (q.size() > DEPTH) void'(q.pop_front());
          m_last  = s;
          m_first = 1'b0;
          if (hit) begin
            post_left = POST;
            m_state   = (POST == 0) ? 3 : 2;
          end else if (m_state == 2) begin
            post_left--;
            if (post_left == 0) m_state = 3;
          end
        end
      end else if (m_state == 3 && bif.rd_req && q.size() > 0) begin
        m_data  = q.pop_front();
        m_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("armed", 64'(armed), 64'(m_state == 1));
      chk("triggered", 64'(triggered), 64'(m_state >= 2));
      chk("done", 64'(done), 64'(m_state == 3));
      chk("rd_valid", 64'(bif.rd_valid), 64'(m_valid));
      chk("rd_data", 64'(bif.rd_data), 64'(m_data));
    end
  end

  task automatic step_raw(input logic [DW-1:0] a, input logic [DW-1:0] d,
                          input logic [CWD-1:0] c, input logic arm_i, input logic rd_i);
    bif.addr   = a;
    bif.data   = d;
    bif.ctrl   = c;
    arm        = arm_i;
    bif.rd_req = rd_i;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [DW-1:0] a, input logic arm_i, input logic rd_i);
    step_raw(a, a ^ 16'h5A5A, a[CWD-1:0], arm_i, rd_i);
  endtask

  initial begin
    bif.addr = '0; bif.data = '0; bif.ctrl = '0; bif.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_status", 64'({armed, triggered, done, bif.rd_valid}), 64'd0);
    chk("reset_rd_data", 64'(bif.rd_data), 64'd0);
    rst_n = 1'b1;
    step(16'h0000, 1'b0, 1'b1);
    chk("idle_rd_ignored", 64'(bif.rd_valid), 64'd0);

    // Basic window: counting address, trigger at 0x000A.
    trig_addr = 16'h000A; trig_mask = 16'hFFFF;
    step(16'hFFFF, 1'b1, 1'b0);
    chk("arm_armed", 64'(armed), 64'd1);
    chk("arm_count", 64'(count), 64'd0);
    for (int a = 0; a <= 12; a++) step(16'(a), 1'b0, 1'b0);
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_count", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      step(16'h0100, 1'b0, 1'b1);
      chk("basic_rd_valid", 64'(bif.rd_valid), 64'd1);
      chk("basic_rd_addr", 64'(bif.rd_data[EW-1 -: DW]), 64'(5 + i));
    end
    chk("basic_empty", 64'(count), 64'd0);
    step(16'h0100, 1'b0, 1'b1);
    chk("basic_extra_rd", 64'(bif.rd_valid), 64'd0);

    // Masked trigger.
    trig_addr = 16'h1200; trig_mask = 16'hFF00;
    step(16'h0000, 1'b1, 1'b0);
    step(16'h1100, 1'b0, 1'b0);
    step(16'h11FF, 1'b0, 1'b0);
    chk("mask_not_trig", 64'(triggered), 64'd0);
    step(16'h1234, 1'b0, 1'b0);
    chk("mask_trig", 64'(triggered), 64'd1);
    step(16'h1300, 1'b0, 1'b0);
    step(16'h1301, 1'b0, 1'b0);
    chk("mask_count", 64'(count), 64'd5);
    step(16'h0000, 1'b0, 1'b1);
    chk("mask_first_rd", 64'(bif.rd_data[EW-1 -: DW]), 64'h1100);

    // Short pre-trigger window.
    trig_addr = 16'h0002; trig_mask = 16'hFFFF;
    step(16'h0000, 1'b1, 1'b0);
    for (int a = 1; a <= 4; a++) step(16'(a), 1'b0, 1'b0);
    chk("short_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      step(16'h0000, 1'b0, 1'b1);
      chk("short_rd_addr", 64'(bif.rd_data[EW-1 -: DW]), 64'(1 + i));
    end
    step(16'h0000, 1'b0, 1'b1);
    chk("short_extra_rd", 64'(bif.rd_valid), 64'd0);

    // arm beats rd_req while entries remain.
    step(16'h0000, 1'b1, 1'b0);
    for (int a = 1; a <= 4; a++) step(16'(a), 1'b0, 1'b0);
    step(16'h0000, 1'b1, 1'b1);
    chk("armrd_valid", 64'(bif.rd_valid), 64'd0);
    chk("armrd_count", 64'(count), 64'd0);
    chk("armrd_armed", 64'(armed), 64'd1);

    // Reset in the middle of POST.
    step(16'h0001, 1'b0, 1'b0);
    step(16'h0002, 1'b0, 1'b0);
    chk("pre_reset_trig", 64'(triggered), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_status", 64'({armed, triggered, done, bif.rd_valid}), 64'd0);
    chk("rst_rd_data", 64'(bif.rd_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(16'h0000, 1'b0, 1'b1);
    chk("post_rst_rd", 64'(bif.rd_valid), 64'd0);

`ifdef TRACE_CHANGE_ONLY_EN
    trig_addr = 16'h0010; trig_mask = 16'hFFFF;
    step(16'h0000, 1'b1, 1'b0);
    repeat (5) step_raw(16'h0003, 16'h00FF, 14'h0001, 1'b0, 1'b0);
    chk("chg_one_entry", 64'(count), 64'd1);
    step(16'h0010, 1'b0, 1'b0);
    step(16'h0011, 1'b0, 1'b0);
    step(16'h0012, 1'b0, 1'b0);
    chk("chg_count", 64'(count), 64'd4);
    step(16'h0000, 1'b0, 1'b1);
    chk("chg_first_rd", 64'(bif.rd_data), 64'({16'h0003, 16'h00FF, 14'h0001}));
`endif

    step(16'h0000, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
